tinker_mem_arbiter: RTL and testbench

Single-port memory arbiter for the tinker pipelined core. It shares one unified instruction/data memory port between the fetch stage (32-bit instruction reads) and the memory stage (64-bit loads and stores). The block sequences one outstanding transaction at a time through a request/ready/rvalid handshake, gives the data port priority, and supports fetch kill on branch flush. It sits between the core pipeline registers and the memory backing store.

---
 rtl/tinker_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_tinker_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_mem_arbiter.sv
// Single-port memory arbiter sharing one memory port between instruction fetch and data loads/stores.
// Optional fetch-starvation guard is compiled in with `define TINKER_ARB_STARVE_EN.
module tinker_mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshake: a command transfers in the cycle mem_req && mem_ready; the winning
    // requester's gnt pulses in that same cycle, and read data returns later on mem_rvalid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   kill_q;
    logic   starve_force;
    logic   d_win, f_win;

`ifdef TINKER_ARB_STARVE_EN
    localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    logic [CW-1:0] starve_cnt;

    // A killed fetch is not competing, so it cannot claim the forced win either.
    assign starve_force = (starve_cnt == CW'(STARVE_MAX)) && if_req && !if_kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && if_req && (starve_cnt != CW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        d_win     = 1'b0;
        f_win     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        case (state)
            IDLE: begin
                d_win   = d_req && !starve_force;
                f_win   = !d_win && if_req && !if_kill;
                mem_req = d_win || f_win;
                if (d_win) begin
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                end else if (f_win) begin
                    mem_addr = if_addr;
                end
                d_gnt  = d_win && mem_ready;
                if_gnt = f_win && mem_ready;
                // Stores complete on acceptance and leave the port free next cycle.
                if (if_gnt) begin
                    state_nxt = RD_IF;
                end else if (d_gnt && !d_we) begin
                    state_nxt = RD_D;
                end
            end
            RD_IF, RD_D: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            kill_q    <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (state == RD_IF && mem_rvalid) begin
                if_rdata  <= mem_rdata[31:0];
                if_rvalid <= !(kill_q || if_kill);
            end
            if (state == RD_D && mem_rvalid) begin
                d_rdata  <= mem_rdata;
                d_rvalid <= 1'b1;
            end
            if (state_nxt == IDLE) begin
                kill_q <= 1'b0;
            end else if (state == RD_IF && if_kill) begin
                kill_q <= 1'b1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Self-checking bench for tinker_mem_arbiter: directed scenarios plus randomised reads,
// with read data tracked through expected-value queues.
module tb_tinker_mem_arbiter;

    localparam int STARVE_MAX = 4;
`ifdef TINKER_ARB_STARVE_EN
    localparam int N_D_FIRST = STARVE_MAX;
`else
    localparam int N_D_FIRST = 6;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_kill;
    logic [63:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [63:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [63:0] d_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [63:0] mem_rdata;
    logic        busy;
    logic [1:0]  state_dbg;

    logic [63:0] if_exp_q[$];
    logic [63:0] d_exp_q[$];
    int n_checks = 0;
    int n_err = 0;

    tinker_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver tasks: cyc starts a cycle (inputs change), smp moves to the sampling point
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 0; if_kill = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    // scoreboard: every response pops the queue of its port
    always @(negedge clk) begin
        if (if_rvalid) begin
            if (if_exp_q.size() == 0) check("if_rvalid_unexpected", 1, 0);
            else check("if_rdata", {32'h0, if_rdata}, if_exp_q.pop_front());
        end
        if (d_rvalid) begin
            if (d_exp_q.size() == 0) check("d_rvalid_unexpected", 1, 0);
            else check("d_rdata", d_rdata, d_exp_q.pop_front());
        end
    end

    initial begin
        logic [63:0] data;
        int ngnt;
        reset = 1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 reset = 0;
        smp();
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_state", state_dbg, 0);

        // fetch only
        cyc(); if_req = 1; if_addr = 64'h2000; mem_ready = 1;
        smp();
        check("f_if_gnt", if_gnt, 1);
        check("f_d_gnt", d_gnt, 0);
        check("f_mem_req", mem_req, 1);
        check("f_mem_addr", mem_addr, 64'h2000);
        check("f_mem_we", mem_we, 0);
        check("f_mem_wdata", mem_wdata, 0);
        check("f_busy0", busy, 0);
        if_exp_q.push_back(64'hAABBCCDD);
        cyc(); if_req = 0; mem_ready = 0;
        smp();
        check("f_busy1", busy, 1);
        check("f_mem_req_rd", mem_req, 0);
        cyc(); mem_rvalid = 1; mem_rdata = 64'h11223344_AABBCCDD;
        smp();
        check("f_busy2", busy, 1);
        check("f_if_rvalid_early", if_rvalid, 0);
        cyc(); mem_rvalid = 0;
        smp();
        check("f_if_rvalid", if_rvalid, 1);
        check("f_busy3", busy, 0);
        cyc();
        smp();
        check("f_if_rvalid_pulse", if_rvalid, 0);
        check("f_if_rdata_hold", {32'h0, if_rdata}, 64'hAABBCCDD);

        // simultaneous fetch and load: data first
        cyc(); if_req = 1; if_addr = 64'h2040; d_req = 1; d_we = 0; d_addr = 64'h3000; mem_ready = 1;
        smp();
        check("s_d_gnt", d_gnt, 1);
        check("s_if_gnt", if_gnt, 0);
        check("s_mem_addr", mem_addr, 64'h3000);
        d_exp_q.push_back(64'hDEAD0000_BEEF1111);
        cyc(); d_req = 0;
        smp();
        check("s_if_gnt_wait", if_gnt, 0);
        check("s_mem_req_rd", mem_req, 0);
        cyc(); mem_rvalid = 1; mem_rdata = 64'hDEAD0000_BEEF1111;
        smp();
        check("s_if_gnt_rv", if_gnt, 0);
        cyc(); mem_rvalid = 0;
        smp();
        check("s_if_gnt_after", if_gnt, 1);
        check("s_mem_addr_f", mem_addr, 64'h2040);
        check("s_d_rvalid", d_rvalid, 1);
        if_exp_q.push_back(64'h55667788);
        cyc(); if_req = 0; mem_ready = 0;
        cyc(); mem_rvalid = 1; mem_rdata = 64'h01020304_55667788;
        cyc(); mem_rvalid = 0;
        smp();
        check("s_if_rvalid", if_rvalid, 1);

        // store streak with fetch waiting
        ngnt = 0;
        for (int c = 0; c <= N_D_FIRST; c++) begin
            cyc();
            if_req = 1; if_addr = 64'h2080; mem_ready = 1;
            d_req = (ngnt < 6); d_we = 1;
            d_addr = 64'h4000 + 64'(8 * ngnt); d_wdata = 64'hC0DE_0000 + 64'(ngnt);
            smp();
            check($sformatf("st_d_gnt%0d", c), d_gnt, (c < N_D_FIRST) ? 1 : 0);
            check($sformatf("st_if_gnt%0d", c), if_gnt, (c == N_D_FIRST) ? 1 : 0);
            if (c < N_D_FIRST) begin
                check($sformatf("st_wdata%0d", c), mem_wdata, 64'hC0DE_0000 + 64'(c));
                check($sformatf("st_we%0d", c), mem_we, 1);
            end else begin
                check("st_f_we", mem_we, 0);
            end
            if (d_gnt) ngnt++;
        end
        if_exp_q.push_back(64'h0BADF00D);
        cyc(); if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        cyc(); mem_rvalid = 1; mem_rdata = 64'h0_0BADF00D;
        cyc(); mem_rvalid = 0;
        smp();
        check("st_if_rvalid", if_rvalid, 1);

        // kill before rvalid
        cyc(); if_req = 1; if_addr = 64'h2100; mem_ready = 1;
        smp();
        check("k_if_gnt", if_gnt, 1);
        cyc(); if_req = 0; mem_ready = 0; if_kill = 1;
        cyc(); if_kill = 0;
        cyc(); mem_rvalid = 1; mem_rdata = 64'h9999;
        cyc(); mem_rvalid = 0; d_req = 1; d_we = 0; d_addr = 64'h3100; mem_ready = 1;
        smp();
        check("k_if_rvalid", if_rvalid, 0);
        check("k_busy", busy, 0);
        check("k_d_gnt", d_gnt, 1);
        d_exp_q.push_back(64'h7777_8888_9999_AAAA);
        cyc(); d_req = 0; mem_ready = 0;
        cyc(); mem_rvalid = 1; mem_rdata = 64'h7777_8888_9999_AAAA;
        cyc(); mem_rvalid = 0;
        smp();
        check("k_d_rvalid", d_rvalid, 1);

        // kill coincident with rvalid
        cyc(); if_req = 1; if_addr = 64'h2140; mem_ready = 1;
        smp();
        check("k2_if_gnt", if_gnt, 1);
        cyc(); if_req = 0; mem_ready = 0;
        cyc(); mem_rvalid = 1; mem_rdata = 64'h1234; if_kill = 1;
        cyc(); mem_rvalid = 0; if_kill = 0;
        smp();
        check("k2_if_rvalid", if_rvalid, 0);
        check("k2_busy", busy, 0);

        // reset during a load, response arrives afterwards
        cyc(); d_req = 1; d_we = 0; d_addr = 64'h3200; mem_ready = 1;
        smp();
        check("r_d_gnt", d_gnt, 1);
        cyc(); d_req = 0; mem_ready = 0; reset = 1;
        cyc(); reset = 0; mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        smp();
        check("r_busy", busy, 0);
        cyc(); mem_rvalid = 0;
        smp();
        check("r_d_rvalid", d_rvalid, 0);
        check("r_if_rvalid", if_rvalid, 0);
        check("r_d_rdata", d_rdata, 0);
        check("r_if_rdata", if_rdata, 0);
        check("r_mem_req", mem_req, 0);
        cyc(); if_req = 1; if_addr = 64'h2200; mem_ready = 1;
        smp();
        check("r_if_gnt", if_gnt, 1);
        if_exp_q.push_back(64'hFACEB00C);
        cyc(); if_req = 0; mem_ready = 0;
        cyc(); mem_rvalid = 1; mem_rdata = 64'h0_FACEB00C;
        cyc(); mem_rvalid = 0;
        smp();
        check("r_if_rvalid", if_rvalid, 1);

        // stale rvalid in IDLE, then a store stalled by mem_ready
        cyc(); mem_rvalid = 1; mem_rdata = 64'h5555;
        cyc(); mem_rvalid = 0; d_req = 1; d_we = 1; d_addr = 64'h5000; d_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
        smp();
        check("st_rvalid_stale", if_rvalid | d_rvalid, 0);
        for (int w = 0; w < 3; w++) begin
            check($sformatf("stall_req%0d", w), mem_req, 1);
            check($sformatf("stall_addr%0d", w), mem_addr, 64'h5000);
            check($sformatf("stall_wdata%0d", w), mem_wdata, 64'hA5A5_5A5A_0F0F_F0F0);
            check($sformatf("stall_gnt%0d", w), d_gnt, 0);
            cyc();
            smp();
        end
        cyc(); mem_ready = 1;
        smp();
        check("stall_d_gnt", d_gnt, 1);
        check("stall_busy", busy, 0);
        cyc(); d_req = 0; d_we = 0; mem_ready = 0;

        // randomised fetches and loads with random stalls and latencies
        for (int t = 0; t < 10; t++) begin
            int is_f, stall, lat;
            is_f = $urandom_range(0, 1);
            stall = $urandom_range(0, 2);
            lat = $urandom_range(0, 3);
            data = {$urandom, $urandom};
            cyc();
            if (is_f != 0) begin if_req = 1; if_addr = 64'($urandom) & ~64'h3; end
            else begin d_req = 1; d_we = 0; d_addr = 64'($urandom) & ~64'h7; end
            for (int w = 0; w < stall; w++) begin
                smp();
                check("rnd_stall_gnt", if_gnt | d_gnt, 0);
                cyc();
            end
            mem_ready = 1;
            smp();
            check("rnd_gnt", (is_f != 0) ? if_gnt : d_gnt, 1);
            if (is_f != 0) if_exp_q.push_back({32'h0, data[31:0]});
            else d_exp_q.push_back(data);
            cyc(); if_req = 0; d_req = 0; mem_ready = 0;
            for (int l = 0; l < lat; l++) begin
                smp();
                check("rnd_busy", busy, 1);
                cyc();
            end
            mem_rvalid = 1; mem_rdata = data;
            cyc(); mem_rvalid = 0;
            smp();
            check("rnd_rvalid", (is_f != 0) ? if_rvalid : d_rvalid, 1);
        end

        cyc();
        smp();
        check("if_q_empty", 64'(if_exp_q.size()), 0);
        check("d_q_empty", 64'(d_exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
